// File: rtl/rs232_rx_sampler.sv
//----------------------------------------------------------------------------
// Module      : rs232_rx_sampler
// Description : UART receive sampler fed by the start-bit edge detector.
//               Centre-samples an LSB-first frame and strobes out the byte.
//               Optional even-parity bit: define RS232_RX_PARITY_EN.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module rs232_rx_sampler #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_edge,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int c_clks_per_bit = CLK_FREQ / BAUD_RATE;
  localparam int c_half_bit     = c_clks_per_bit / 2;
  localparam int c_cnt_w        = $clog2(c_clks_per_bit);
  localparam int c_idx_w        = $clog2(DATA_BITS);

  generate
    if (c_clks_per_bit < 4) begin : g_bad_baud
      $error("rs232_rx_sampler: CLK_FREQ/BAUD_RATE must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
      $error("rs232_rx_sampler: DATA_BITS must be in 5..8");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop_bit;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_error;
  logic                 r_busy;
  logic                 w_half_hit;
  logic                 w_full_hit;

  assign w_half_hit = (r_cnt == c_cnt_w'(c_half_bit - 1));
  assign w_full_hit = (r_cnt == c_cnt_w'(c_clks_per_bit - 1));

`ifdef RS232_RX_PARITY_EN
  logic r_par_result;
  logic r_parity_error;
  assign parity_error = r_parity_error;
`else
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      r_stop_bit    <= 1'b1;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
`ifdef RS232_RX_PARITY_EN
      r_par_result   <= 1'b0;
      r_parity_error <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_edge) begin
            r_state <= ST_START;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_half_hit) begin
            r_cnt <= '0;
            if (!rx_in) begin
              r_state <= ST_DATA;
              r_idx   <= '0;
            end else begin
              // False start: the line went back high before mid start bit
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        ST_DATA: begin
          if (w_full_hit) begin
            r_cnt   <= '0;
            r_shift <= {rx_in, r_shift[DATA_BITS-1:1]};
            if (r_idx == c_idx_w'(DATA_BITS - 1)) begin
`ifdef RS232_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_idx <= r_idx + c_idx_w'(1);
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
`ifdef RS232_RX_PARITY_EN
        ST_PARITY: begin
          if (w_full_hit) begin
            r_cnt        <= '0;
            r_par_result <= (^r_shift) ^ rx_in;
            r_state      <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
`endif
        ST_STOP: begin
          if (w_full_hit) begin
            r_cnt      <= '0;
            r_stop_bit <= rx_in;
            r_state    <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        ST_DONE: begin
          // Back in IDLE half a bit early so an adjacent frame is caught
          r_rx_data     <= r_shift;
          r_rx_valid    <= 1'b1;
          r_frame_error <= ~r_stop_bit;
`ifdef RS232_RX_PARITY_EN
          r_parity_error <= r_par_result;
`endif
          r_cnt   <= '0;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rs232_rx_sampler.sv
//----------------------------------------------------------------------------
// Module      : tb_rs232_rx_sampler
// Description : Scoreboard bench for rs232_rx_sampler at default parameters.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_rs232_rx_sampler;

  localparam int c_cpb = 434;
`ifdef RS232_RX_PARITY_EN
  localparam int c_par = 1;
`else
  localparam int c_par = 0;
`endif
  localparam int c_frame_bits = 1 + 8 + c_par + 1;
  // start pulse 4 edges after the fall, half bit of 217, then whole bits, then one output edge
  localparam int c_latency    = 4 + 217 + c_cpb * (8 + c_par + 1) + 1;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start_edge;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       parity_error;
  logic       busy;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   n_strobes;
  int   cyc;
  int   last_fall_cyc;
  int   last_strobe_cyc;

  rs232_rx_sampler dut (
    .clk          (clk),
    .reset        (reset),
    .start_edge   (start_edge),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_error  (frame_error),
    .parity_error (parity_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic exp_pe(input logic [7:0] d, input logic p);
`ifdef RS232_RX_PARITY_EN
    return (^d) ^ p;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one frame; abort_at >= 0 stops driving 200 clocks into that data bit
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit,
                            input bit spur, input int abort_at);
    rx_in         = 1'b0;
    last_fall_cyc = cyc;
    tick(3);
    start_edge = 1'b1;
    tick(1);
    start_edge = 1'b0;
    tick(c_cpb - 4);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      if (i == abort_at) begin
        tick(200);
        return;
      end
      if (spur && i == 3) begin
        tick(100);
        start_edge = 1'b1;
        tick(1);
        start_edge = 1'b0;
        tick(c_cpb - 101);
      end else begin
        tick(c_cpb);
      end
    end
`ifdef RS232_RX_PARITY_EN
    rx_in = pbit;
    tick(c_cpb);
`else
    if (pbit) begin end
`endif
    rx_in = stop;
    tick(c_cpb);
    rx_in = 1'b1;
  endtask

  // Monitor: pops the scoreboard on each strobe
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && rx_valid) begin
        n_strobes++;
        last_strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e.d});
          check("frame_error", {31'd0, frame_error}, {31'd0, e.fe});
          check("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
          check("busy_at_strobe", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int t1;
    n_checks   = 0;
    n_fail     = 0;
    n_strobes  = 0;
    reset      = 1'b0;
    start_edge = 1'b0;
    rx_in      = 1'b1;
    tick(3);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_frame_error", {31'd0, frame_error}, 32'd0);
    check("rst_parity_error", {31'd0, parity_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    tick(5);

    // Basic 0xA5 frame, latency and busy release
    exp_q.push_back('{d: 8'hA5, fe: 1'b0, pe: exp_pe(8'hA5, ^8'hA5)});
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, -1);
    check("a5_latency", last_strobe_cyc - last_fall_cyc, c_latency);
    check("a5_strobes", n_strobes, 1);
    tick(2);
    check("a5_busy_after", {31'd0, busy}, 32'd0);
    tick(20);

    // Glitch: 50 clocks low with a start pulse
    s0    = n_strobes;
    rx_in = 1'b0;
    tick(3);
    start_edge = 1'b1;
    tick(1);
    start_edge = 1'b0;
    tick(46);
    rx_in = 1'b1;
    tick(50);
    check("glitch_busy_in_start", {31'd0, busy}, 32'd1);
    tick(300);
    check("glitch_busy_after", {31'd0, busy}, 32'd0);
    check("glitch_no_strobe", n_strobes, s0);
    check("glitch_rx_data_held", {24'd0, rx_data}, 32'h0000_00A5);

    // Framing error then a good frame
    exp_q.push_back('{d: 8'h3C, fe: 1'b1, pe: exp_pe(8'h3C, ^8'h3C)});
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0, -1);
    tick(20);
    exp_q.push_back('{d: 8'h12, fe: 1'b0, pe: exp_pe(8'h12, ^8'h12)});
    send_frame(8'h12, 1'b1, ^8'h12, 1'b0, -1);
    tick(20);

    // Back-to-back frames, spurious start pulse inside the second
    s0 = n_strobes;
    exp_q.push_back('{d: 8'h00, fe: 1'b0, pe: exp_pe(8'h00, 1'b0)});
    exp_q.push_back('{d: 8'hFF, fe: 1'b0, pe: exp_pe(8'hFF, 1'b0)});
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, -1);
    t1 = last_strobe_cyc;
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1, -1);
    check("b2b_spacing", last_strobe_cyc - t1, c_cpb * c_frame_bits);
    check("b2b_strobes", n_strobes - s0, 2);
    tick(20);

    // Reset in the middle of data bit 4
    send_frame(8'h81, 1'b1, ^8'h81, 1'b0, 4);
    reset = 1'b0;
    #1;
    check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_frame_error", {31'd0, frame_error}, 32'd0);
    check("midrst_parity_error", {31'd0, parity_error}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rx_in = 1'b1;
    tick(5);
    reset = 1'b1;
    tick(10);
    exp_q.push_back('{d: 8'h7E, fe: 1'b0, pe: exp_pe(8'h7E, ^8'h7E)});
    send_frame(8'h7E, 1'b1, ^8'h7E, 1'b0, -1);
    tick(20);

`ifdef RS232_RX_PARITY_EN
    exp_q.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b0});
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1);
    tick(20);
    exp_q.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b1});
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, -1);
    tick(20);
`endif

    tick(10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
